// File: rtl/mem_pkg.sv
// Shared memory-side definitions: ram RW encodings, arbiter state encoding and
// default bus widths used by the ram arbiter and its winner-select helper.
package mem_pkg;

    localparam int AW_DEF = 32;
    localparam int DW_DEF = 32;

    localparam logic [1:0] RW_WRITE = 2'b00;
    localparam logic [1:0] RW_READ  = 2'b01;
    localparam logic [1:0] RW_IDLE  = 2'b11;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } arb_state_t;

    typedef enum logic {
        SRC_F = 1'b0,
        SRC_D = 1'b1
    } arb_src_t;

    typedef struct packed {
        logic f;
        logic d;
    } pick_t;

endpackage

// File: rtl/ram_arb_pick.sv
// Winner select for the ram arbiter: data has priority unless a fetch has
// watched MAX_DATA_RUN consecutive data grants go by.
module ram_arb_pick
    import mem_pkg::*;
#(
    parameter int MAX_DATA_RUN = 4,
    parameter int RCW          = $clog2(MAX_DATA_RUN + 1)
) (
    input  logic           f_req,
    input  logic           d_req,
    input  logic [RCW-1:0] run_cnt,
    output pick_t          pick
);

    always_comb begin
        pick = '0;
        if (f_req && (!d_req || run_cnt == RCW'(MAX_DATA_RUN)))
            pick.f = 1'b1;
        else if (d_req)
            pick.d = 1'b1;
    end

endmodule

// File: rtl/ram_arbiter.sv
// Shares the single-port ram between instruction fetch (read only) and
// load/store (read/write); one access in flight, all outputs registered.
module ram_arbiter
    import mem_pkg::*;
#(
    parameter int AW           = AW_DEF,
    parameter int DW           = DW_DEF,
    parameter int RAM_LAT      = 1,
    parameter int MAX_DATA_RUN = 4
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          F_REQ,
    input  logic [AW-1:0] F_ADDR,
    output logic          F_GNT,
    output logic          F_VALID,
    output logic [DW-1:0] F_RDATA,
    input  logic          D_REQ,
    input  logic          D_WE,
    input  logic [AW-1:0] D_ADDR,
    input  logic [DW-1:0] D_WDATA,
    output logic          D_GNT,
    output logic          D_VALID,
    output logic [DW-1:0] D_RDATA,
    output logic          RAM_ENABLE,
    output logic [1:0]    RAM_RW,
    output logic [AW-1:0] RAM_ADDR,
    output logic [DW-1:0] RAM_DIN,
    input  logic [DW-1:0] RAM_DOUT
);

    localparam int LCW = $clog2(RAM_LAT + 1);
    localparam int RCW = $clog2(MAX_DATA_RUN + 1);

    arb_state_t     state;
    arb_src_t       src;
    logic           is_rd;
    logic [LCW-1:0] lat_cnt;
    logic [RCW-1:0] run_cnt;
    pick_t          pick;

    ram_arb_pick #(
        .MAX_DATA_RUN (MAX_DATA_RUN),
        .RCW          (RCW)
    ) u_pick (
        .f_req   (F_REQ),
        .d_req   (D_REQ),
        .run_cnt (run_cnt),
        .pick    (pick)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= IDLE;
            src        <= SRC_F;
            is_rd      <= 1'b0;
            lat_cnt    <= '0;
            run_cnt    <= '0;
            RAM_ENABLE <= 1'b0;
            RAM_RW     <= RW_IDLE;
            RAM_ADDR   <= '0;
            RAM_DIN    <= '0;
            F_GNT      <= 1'b0;
            D_GNT      <= 1'b0;
            F_VALID    <= 1'b0;
            D_VALID    <= 1'b0;
            F_RDATA    <= '0;
            D_RDATA    <= '0;
        end else begin
            F_GNT   <= 1'b0;
            D_GNT   <= 1'b0;
            F_VALID <= 1'b0;
            D_VALID <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick.f) begin
                        src        <= SRC_F;
                        is_rd      <= 1'b1;
                        RAM_ADDR   <= F_ADDR;
                        RAM_RW     <= RW_READ;
                        RAM_DIN    <= '0;
                        RAM_ENABLE <= 1'b1;
                        lat_cnt    <= LCW'(RAM_LAT);
                        F_GNT      <= 1'b1;
                        run_cnt    <= '0;
                        state      <= ACCESS;
                    end else if (pick.d) begin
                        src        <= SRC_D;
                        is_rd      <= !D_WE;
                        RAM_ADDR   <= D_ADDR;
                        RAM_RW     <= D_WE ? RW_WRITE : RW_READ;
                        RAM_DIN    <= D_WE ? D_WDATA : '0;
                        RAM_ENABLE <= 1'b1;
                        lat_cnt    <= LCW'(RAM_LAT);
                        D_GNT      <= 1'b1;
                        state      <= ACCESS;
                        // only data grants that make a waiting fetch wait longer count
                        if (!F_REQ)
                            run_cnt <= '0;
                        else if (run_cnt != RCW'(MAX_DATA_RUN))
                            run_cnt <= run_cnt + 1'b1;
                    end
                end
                ACCESS: begin
                    lat_cnt <= lat_cnt - 1'b1;
                    if (lat_cnt == LCW'(1)) begin
                        if (is_rd) begin
                            if (src == SRC_F)
                                F_RDATA <= RAM_DOUT;
                            else
                                D_RDATA <= RAM_DOUT;
                        end
                        RAM_ENABLE <= 1'b0;
                        RAM_RW     <= RW_IDLE;
                        F_VALID    <= (src == SRC_F);
                        D_VALID    <= (src == SRC_D);
                        state      <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: directed scenarios plus randomized fetch/data traffic
// against a word-array memory model, with a grant/valid scoreboard monitor.
module tb_ram_arbiter;
    import mem_pkg::*;

    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int MAXR = 4;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    logic pre = 1'b1;
    always #5 CLK = ~CLK;

    logic          F_REQ = 1'b0, D_REQ = 1'b0, D_WE = 1'b0;
    logic [AW-1:0] F_ADDR = '0, D_ADDR = '0;
    logic [DW-1:0] D_WDATA = '0;
    logic          F_GNT, F_VALID, D_GNT, D_VALID, RAM_ENABLE;
    logic [DW-1:0] F_RDATA, D_RDATA, RAM_DIN, RAM_DOUT;
    logic [1:0]    RAM_RW;
    logic [AW-1:0] RAM_ADDR;

    logic          f3_req = 1'b0, d3_req = 1'b0, d3_we = 1'b0;
    logic [AW-1:0] f3_addr = '0, d3_addr = '0;
    logic [DW-1:0] d3_wdata = '0;
    logic          f3_gnt, f3_valid, d3_gnt, d3_valid, r3_en;
    logic [DW-1:0] f3_rdata, d3_rdata, r3_din, r3_dout;
    logic [1:0]    r3_rw;
    logic [AW-1:0] r3_addr;

    ram_arbiter #(.AW(AW), .DW(DW), .RAM_LAT(1), .MAX_DATA_RUN(MAXR)) u_dut (
        .CLK(CLK), .RST(RST),
        .F_REQ(F_REQ), .F_ADDR(F_ADDR), .F_GNT(F_GNT), .F_VALID(F_VALID), .F_RDATA(F_RDATA),
        .D_REQ(D_REQ), .D_WE(D_WE), .D_ADDR(D_ADDR), .D_WDATA(D_WDATA),
        .D_GNT(D_GNT), .D_VALID(D_VALID), .D_RDATA(D_RDATA),
        .RAM_ENABLE(RAM_ENABLE), .RAM_RW(RAM_RW), .RAM_ADDR(RAM_ADDR),
        .RAM_DIN(RAM_DIN), .RAM_DOUT(RAM_DOUT)
    );

    ram_arbiter #(.AW(AW), .DW(DW), .RAM_LAT(3), .MAX_DATA_RUN(MAXR)) u_dut3 (
        .CLK(CLK), .RST(RST),
        .F_REQ(f3_req), .F_ADDR(f3_addr), .F_GNT(f3_gnt), .F_VALID(f3_valid), .F_RDATA(f3_rdata),
        .D_REQ(d3_req), .D_WE(d3_we), .D_ADDR(d3_addr), .D_WDATA(d3_wdata),
        .D_GNT(d3_gnt), .D_VALID(d3_valid), .D_RDATA(d3_rdata),
        .RAM_ENABLE(r3_en), .RAM_RW(r3_rw), .RAM_ADDR(r3_addr),
        .RAM_DIN(r3_din), .RAM_DOUT(r3_dout)
    );

    function automatic logic [31:0] init_word(input int i);
        if (i == 5) return 32'hE59F1004;
        return 32'hA5000000 ^ (32'(i) * 32'h00010203);
    endfunction

    // 16-word ram models; the latency-3 instance only ever reads
    logic [DW-1:0] mem1 [16];
    always @(posedge CLK) begin
        if (pre) begin
            for (int i = 0; i < 16; i++) mem1[i] <= init_word(i);
        end else if (RAM_ENABLE && RAM_RW == RW_WRITE) begin
            mem1[RAM_ADDR[3:0]] <= RAM_DIN;
        end
    end
    assign RAM_DOUT = mem1[RAM_ADDR[3:0]];
    assign r3_dout  = init_word(int'(r3_addr[3:0]));

    int n_chk = 0, n_pass = 0, cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp, cyc);
    endtask

    // reference model and scoreboard
    typedef struct {
        logic [DW-1:0] data;
        int            gc;
    } exp_t;
    exp_t          fq[$], dq[$];
    logic [DW-1:0] model [16];
    logic [DW-1:0] last_rd;
    int            drun, d_gnt_cnt;

    initial begin
        exp_t e;
        for (int i = 0; i < 16; i++) model[i] = init_word(i);
        last_rd = '0; drun = 0; d_gnt_cnt = 0;
        forever begin
            @(posedge CLK); #1;
            if (RST) begin
                fq.delete(); dq.delete(); last_rd = '0; drun = 0;
            end else begin
                if (F_GNT && D_GNT) chk("dual_gnt", 1, 0);
                if (F_GNT) begin
                    chk("f_gnt_rw", RAM_RW, RW_READ);
                    chk("f_gnt_addr", RAM_ADDR, F_ADDR);
                    chk("f_gnt_en", RAM_ENABLE, 1);
                    e.data = model[F_ADDR[3:0]]; e.gc = cyc;
                    fq.push_back(e);
                    drun = 0;
                end
                if (D_GNT) begin
                    d_gnt_cnt++;
                    chk("d_gnt_addr", RAM_ADDR, D_ADDR);
                    chk("d_gnt_en", RAM_ENABLE, 1);
                    if (D_WE) begin
                        chk("d_gnt_rw", RAM_RW, RW_WRITE);
                        chk("d_gnt_din", RAM_DIN, D_WDATA);
                        model[D_ADDR[3:0]] = D_WDATA;
                    end else begin
                        chk("d_gnt_rw", RAM_RW, RW_READ);
                        chk("d_gnt_din", RAM_DIN, 0);
                        last_rd = model[D_ADDR[3:0]];
                    end
                    e.data = last_rd; e.gc = cyc;
                    dq.push_back(e);
                    if (F_REQ) begin
                        drun++;
                        chk("fetch_starved", drun <= MAXR, 1);
                    end else begin
                        drun = 0;
                    end
                end
                if (F_VALID) begin
                    if (fq.size() == 0) chk("f_valid_unexpected", 1, 0);
                    else begin
                        e = fq.pop_front();
                        chk("f_rdata", F_RDATA, e.data);
                        chk("f_latency", cyc - e.gc, 1);
                    end
                end
                if (D_VALID) begin
                    if (dq.size() == 0) chk("d_valid_unexpected", 1, 0);
                    else begin
                        e = dq.pop_front();
                        chk("d_rdata", D_RDATA, e.data);
                        chk("d_latency", cyc - e.gc, 1);
                    end
                end
            end
        end
    end

    task automatic wait_gnt(input bit is_f, input int lim, output bit got);
        got = 1'b0;
        for (int k = 0; k < lim && !got; k++) begin
            @(posedge CLK); #1;
            got = is_f ? F_GNT : D_GNT;
        end
    endtask

    task automatic drv_f(input int n);
        bit g;
        for (int i = 0; i < n; i++) begin
            @(negedge CLK);
            F_ADDR = AW'($urandom_range(0, 15)); F_REQ = 1'b1;
            wait_gnt(1'b1, 40, g);
            if (!g) chk("f_gnt_timeout", 0, 1);
            @(negedge CLK); F_REQ = 1'b0;
            repeat ($urandom_range(0, 3)) @(negedge CLK);
        end
    endtask

    task automatic drv_d(input int n);
        bit g;
        for (int i = 0; i < n; i++) begin
            @(negedge CLK);
            D_ADDR = AW'($urandom_range(0, 15)); D_WE = 1'($urandom_range(0, 1));
            D_WDATA = $urandom; D_REQ = 1'b1;
            wait_gnt(1'b0, 40, g);
            if (!g) chk("d_gnt_timeout", 0, 1);
            @(negedge CLK); D_REQ = 1'b0;
            repeat ($urandom_range(0, 3)) @(negedge CLK);
        end
    endtask

    task automatic lat3_acc(input bit is_f, input logic [3:0] a);
        int en, vc;
        @(negedge CLK);
        if (is_f) begin f3_addr = AW'(a); f3_req = 1'b1; end
        else begin d3_addr = AW'(a); d3_we = 1'b0; d3_req = 1'b1; end
        @(posedge CLK); #1;
        chk(is_f ? "l3_f_gnt" : "l3_d_gnt", is_f ? f3_gnt : d3_gnt, 1);
        en = int'(r3_en); vc = 0;
        @(negedge CLK); f3_req = 1'b0; d3_req = 1'b0;
        for (int k = 2; k <= 20 && vc == 0; k++) begin
            @(posedge CLK); #1;
            if (r3_en) en++;
            if (is_f ? f3_valid : d3_valid) vc = k;
        end
        chk("l3_valid_cycle", vc, 4);
        chk("l3_enable_cycles", en, 3);
        chk("l3_rdata", is_f ? f3_rdata : d3_rdata, init_word(int'(a)));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $fatal(1, "watchdog");
    end

    initial begin
        bit g;
        logic [9:0] order;
        int n, dg;
        logic [DW-1:0] old;

        // reset values
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_en", RAM_ENABLE, 0);   chk("rst_rw", RAM_RW, RW_IDLE);
        chk("rst_addr", RAM_ADDR, 0);   chk("rst_din", RAM_DIN, 0);
        chk("rst_gnt", {F_GNT, D_GNT, F_VALID, D_VALID}, 0);
        chk("rst_rdata", {F_RDATA, D_RDATA}, 0);
        @(negedge CLK); RST = 1'b0; pre = 1'b0;
        repeat (2) @(negedge CLK);

        // single fetch
        F_ADDR = 5; F_REQ = 1'b1;
        @(posedge CLK); #1;
        chk("fetch_gnt", F_GNT, 1); chk("fetch_rw", RAM_RW, RW_READ); chk("fetch_addr", RAM_ADDR, 5);
        @(negedge CLK); F_REQ = 1'b0;
        @(posedge CLK); #1;
        chk("fetch_valid", F_VALID, 1); chk("fetch_rdata", F_RDATA, 32'hE59F1004);
        repeat (2) @(negedge CLK);

        // write then read back
        D_ADDR = 7; D_WE = 1'b1; D_WDATA = 32'hDEADBEEF; D_REQ = 1'b1;
        @(posedge CLK); #1;
        chk("wr_gnt", D_GNT, 1); chk("wr_rw", RAM_RW, RW_WRITE); chk("wr_din", RAM_DIN, 32'hDEADBEEF);
        @(negedge CLK); D_REQ = 1'b0;
        @(posedge CLK); #1;
        chk("wr_valid", D_VALID, 1); chk("wr_rdata_kept", D_RDATA, 0);
        @(negedge CLK); D_WE = 1'b0; D_REQ = 1'b1;
        wait_gnt(1'b0, 10, g); chk("rd_gnt", g, 1);
        @(negedge CLK); D_REQ = 1'b0;
        @(posedge CLK); #1;
        chk("rd_valid", D_VALID, 1); chk("rd_rdata", D_RDATA, 32'hDEADBEEF);
        repeat (2) @(negedge CLK);

        // contention: both held high for ten grants
        F_ADDR = 1; D_ADDR = 2; D_WE = 1'b0; F_REQ = 1'b1; D_REQ = 1'b1;
        order = '0; n = 0;
        for (int k = 0; k < 80 && n < 10; k++) begin
            @(posedge CLK); #1;
            if (F_GNT) begin order[n] = 1'b1; n++; end
            else if (D_GNT) n++;
        end
        @(negedge CLK); F_REQ = 1'b0; D_REQ = 1'b0;
        chk("contention_count", n, 10);
        chk("contention_order", order, 10'b10000_10000);
        repeat (3) @(negedge CLK);

        // data request withdrawn while a fetch is in progress
        F_ADDR = 3; F_REQ = 1'b1;
        wait_gnt(1'b1, 10, g); chk("wd_fetch_gnt", g, 1);
        dg = d_gnt_cnt; old = model[9];
        @(negedge CLK);
        F_REQ = 1'b0; D_ADDR = 9; D_WE = 1'b1; D_WDATA = 32'h0BADF00D; D_REQ = 1'b1;
        @(negedge CLK); D_REQ = 1'b0;
        repeat (6) @(posedge CLK);
        #1;
        chk("wd_no_gnt", d_gnt_cnt, dg); chk("wd_mem", mem1[9], old);

        // random mixed traffic
        fork
            drv_f(30);
            drv_d(30);
        join
        for (int k = 0; k < 20 && (fq.size() + dq.size()) != 0; k++) @(posedge CLK);
        #2;
        chk("drain", fq.size() + dq.size(), 0);

        // latency sweep on the RAM_LAT=3 instance
        lat3_acc(1'b1, 4'd4);
        repeat (2) @(negedge CLK);
        lat3_acc(1'b0, 4'd6);
        repeat (2) @(negedge CLK);

        // reset while a fetch is in ACCESS
        F_ADDR = 5; F_REQ = 1'b1;
        wait_gnt(1'b1, 10, g); chk("ra_fetch_gnt", g, 1);
        RST = 1'b1; F_REQ = 1'b0;
        repeat (2) begin
            @(posedge CLK); #1;
            chk("ra_no_valid", {F_VALID, D_VALID}, 0);
        end
        chk("ra_en", RAM_ENABLE, 0); chk("ra_rw", RAM_RW, RW_IDLE);
        chk("ra_rdata", {F_RDATA, D_RDATA}, 0);
        @(negedge CLK); RST = 1'b0;
        repeat (3) begin
            @(posedge CLK); #1;
            chk("ra_post_valid", {F_VALID, D_VALID, F_GNT, D_GNT}, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
